bus_arbiter_4way: RTL and testbench

//  Round-robin arbiter that shares one DATA_WIDTH-bit output channel between 4 requesters.

---
 rtl/bus_arbiter_4way_if.sv | 44 ++++
 rtl/bus_arbiter_4way.sv | 135 +++++++++++++
 tb/tb_bus_arbiter_4way.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_4way_if.sv
// Purpose : handshake/bus bundle between four requesters, the shared result
//           consumer and bus_arbiter_4way.
// Signals : req[3:0], req_data0..3   requester side (into the arbiter)
//           lock[3:0]                per-requester hold (ARB_LOCK_EN builds only)
//           out_valid, out_data      stream toward the consumer
//           out_ready                consumer accept
//           mux_sel[1:0], ack[3:0]   grant index and one-cycle transfer ack
//           busy                     arbiter is in its grant phase
// Modports: master = producers/consumer view, slave = arbiter view.
// Macro   : ARB_LOCK_EN adds the lock vector.
interface bus_arbiter_4way_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [3:0]            req;
    logic [DATA_WIDTH-1:0] req_data0;
    logic [DATA_WIDTH-1:0] req_data1;
    logic [DATA_WIDTH-1:0] req_data2;
    logic [DATA_WIDTH-1:0] req_data3;
`ifdef ARB_LOCK_EN
    logic [3:0]            lock;
`endif
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic [1:0]            mux_sel;
    logic [3:0]            ack;
    logic                  busy;

    modport master (
        output req, req_data0, req_data1, req_data2, req_data3, out_ready,
        input  out_valid, out_data, mux_sel, ack, busy
`ifdef ARB_LOCK_EN
        , output lock
`endif
    );

    modport slave (
        input  req, req_data0, req_data1, req_data2, req_data3, out_ready,
        output out_valid, out_data, mux_sel, ack, busy
`ifdef ARB_LOCK_EN
        , input lock
`endif
    );
endinterface

// File: rtl/bus_arbiter_4way.sv
// Purpose : round-robin arbiter sharing one DATA_WIDTH-bit result channel
//           between four requesters. Drives the select of a 4-way payload mux,
//           presents a valid/ready stream to the consumer and pulses a one-hot
//           ack to the winner in its transfer cycle.
// Ports   : clk   - rising-edge clock
//           reset - asynchronous, active-high
//           bus   - bus_arbiter_4way_if.slave (req/req_data*/out_ready in;
//                   out_valid/out_data/mux_sel/ack/busy out; lock in with lock)
// Params  : DATA_WIDTH (16/32/64), HOLD_LIMIT (lock builds only)
// Macro   : ARB_LOCK_EN enables per-requester lock with a bounded hold counter.
module bus_arbiter_4way #(
    parameter int unsigned DATA_WIDTH = 32
`ifdef ARB_LOCK_EN
    ,
    parameter int unsigned HOLD_LIMIT = 15
`endif
) (
    input  logic              clk,
    input  logic              reset,
    bus_arbiter_4way_if.slave bus
);
    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       sel_q, sel_d;
    logic [N_REQ-1:0]       ack_c;
    logic [IDX_W-1:0]       win_idx_c;
    logic                   win_vld_c;
    logic [DATA_WIDTH-1:0]  out_data_c;

`ifdef ARB_LOCK_EN
    localparam int unsigned HOLD_W = (HOLD_LIMIT < 1) ? 1 : $clog2(HOLD_LIMIT + 1);
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
`endif

    // Round-robin search: scanning offsets high-to-low leaves the lowest
    // offset from ptr_q that has a request as the winner.
    always_comb begin
        win_vld_c = 1'b0;
        win_idx_c = ptr_q;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (bus.req[IDX_W'(ptr_q + IDX_W'(i))]) begin
                win_vld_c = 1'b1;
                win_idx_c = IDX_W'(ptr_q + IDX_W'(i));
            end
        end
    end

    // Next-state and ack decode.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        ack_c   = '0;
`ifdef ARB_LOCK_EN
        hold_cnt_d = hold_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_vld_c) begin
                    sel_d   = win_idx_c;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (bus.out_ready) begin
                    ack_c[sel_q] = 1'b1;
`ifdef ARB_LOCK_EN
                    // Locked owner keeps the channel for back-to-back transfers
                    // until the hold budget is spent.
                    if (bus.lock[sel_q] && bus.req[sel_q] &&
                        (hold_cnt_q < HOLD_W'(HOLD_LIMIT))) begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end else begin
                        hold_cnt_d = '0;
                        ptr_d      = sel_q + IDX_W'(1);
                        state_d    = IDLE;
                    end
`else
                    ptr_d   = sel_q + IDX_W'(1);
                    state_d = IDLE;
`endif
                end else if (!bus.req[sel_q]) begin
                    // Requester withdrew before being served: drop the grant,
                    // leave the priority pointer where it was.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
`ifdef ARB_LOCK_EN
            hold_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
`ifdef ARB_LOCK_EN
            hold_cnt_q <= hold_cnt_d;
`endif
        end
    end

    // 4-way payload mux steered by the registered grant index.
    always_comb begin
        case (sel_q)
            2'd0:    out_data_c = bus.req_data0;
            2'd1:    out_data_c = bus.req_data1;
            2'd2:    out_data_c = bus.req_data2;
            default: out_data_c = bus.req_data3;
        endcase
    end

    assign bus.out_valid = (state_q == GRANT);
    assign bus.busy      = (state_q == GRANT);
    assign bus.mux_sel   = sel_q;
    assign bus.ack       = ack_c;
    assign bus.out_data  = out_data_c;

endmodule

// File: tb/tb_bus_arbiter_4way.sv
// Bench for bus_arbiter_4way: directed scenarios with hand-computed expectations
// plus a cycle-by-cycle reference model of the arbitration rules.
// Macro: ARB_LOCK_EN enables the lock scenario (HOLD_LIMIT=3).
module tb_bus_arbiter_4way;
    localparam int unsigned DW = 32;
    localparam int          HL = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    req_v;
    logic          rdy_v;
    logic [3:0]    lock_v;
    logic [DW-1:0] dat [4];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int ack_log[$];
    int ack_cyc[$];
    int e_idx[8];
    int e_gap[8];

    bus_arbiter_4way_if #(.DATA_WIDTH(DW)) bus ();

    assign bus.req       = req_v;
    assign bus.out_ready = rdy_v;
    assign bus.req_data0 = dat[0];
    assign bus.req_data1 = dat[1];
    assign bus.req_data2 = dat[2];
    assign bus.req_data3 = dat[3];
`ifdef ARB_LOCK_EN
    assign bus.lock      = lock_v;
`endif

    bus_arbiter_4way #(
        .DATA_WIDTH(DW)
`ifdef ARB_LOCK_EN
        , .HOLD_LIMIT(HL)
`endif
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: who holds the channel, who is next in line, how long held.
    bit m_g;
    int m_sel, m_ptr, m_hold;
    initial begin
        m_g = 0; m_sel = 0; m_ptr = 0; m_hold = 0;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_g = 0; m_sel = 0; m_ptr = 0; m_hold = 0;
        end else if (!m_g) begin
            bit found;
            found = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && req_v[(m_ptr + k) % 4]) begin
                    found = 1;
                    m_sel = (m_ptr + k) % 4;
                end
            end
            m_g = found;
        end else if (rdy_v) begin
            if (lock_v[m_sel] && req_v[m_sel] && m_hold < HL) begin
                m_hold++;
            end else begin
                m_ptr  = (m_sel + 1) % 4;
                m_hold = 0;
                m_g    = 0;
            end
        end else if (!req_v[m_sel]) begin
            m_g = 0;
        end
    end

    // Every-cycle comparison against the model, plus a log of served requesters.
    logic [3:0] exp_ack;
    always @(negedge clk) begin
        exp_ack = (m_g && rdy_v) ? 4'(1 << m_sel) : 4'b0;
        chk("out_valid", 64'(bus.out_valid), 64'(m_g));
        chk("busy",      64'(bus.busy),      64'(m_g));
        chk("mux_sel",   64'(bus.mux_sel),   64'(m_sel));
        chk("ack",       64'(bus.ack),       64'(exp_ack));
        chk("out_data",  64'(bus.out_data),  64'(dat[m_sel]));
        chk("ack_onehot", 64'($countones(bus.ack) <= 1), 64'(1));
        if (bus.ack != 4'b0) begin
            for (int i = 0; i < 4; i++)
                if (bus.ack[i]) ack_log.push_back(i);
            ack_cyc.push_back(cyc);
        end
    end

    task automatic chk_log(input string name, input int n);
        chk({name, "_count"}, 64'(ack_log.size()), 64'(n));
        for (int i = 0; i < n && i < ack_log.size(); i++) begin
            chk({name, "_idx"}, 64'(ack_log[i]), 64'(e_idx[i]));
            if (i > 0) chk({name, "_gap"}, 64'(ack_cyc[i] - ack_cyc[i-1]), 64'(e_gap[i]));
        end
    endtask

    task automatic clear_log();
        ack_log.delete();
        ack_cyc.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] vec [16] = '{5'h1F, 5'h05, 5'h0A, 5'h08, 5'h18, 5'h10, 5'h03, 5'h13,
                             5'h00, 5'h1C, 5'h0C, 5'h04, 5'h16, 5'h12, 5'h01, 5'h00};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        req_v  = 4'b1111;
        rdy_v  = 1'b1;
        lock_v = 4'b0000;
        dat[0] = 32'hA000_0000;
        dat[1] = 32'hB111_1111;
        dat[2] = 32'hC222_2222;
        dat[3] = 32'hD333_3333;

        // Reset held with all requests pending.
        tick(); tick();
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_ack",       64'(bus.ack),       64'(0));
        chk("rst_mux_sel",   64'(bus.mux_sel),   64'(0));
        chk("rst_busy",      64'(bus.busy),      64'(0));
        chk("rst_out_data",  64'(bus.out_data),  64'(32'hA000_0000));
        reset = 1'b0;
        clear_log();
        tick();
        chk("first_grant_valid", 64'(bus.out_valid), 64'(1));
        chk("first_grant_sel",   64'(bus.mux_sel),   64'(0));
        chk("first_grant_ack",   64'(bus.ack),       64'(4'b0001));

        // Rotation 0,1,2,3,0 at one transfer every two cycles.
        repeat (8) tick();
        req_v = 4'b0000;
        tick();
        e_idx = '{0, 1, 2, 3, 0, 0, 0, 0};
        e_gap = '{0, 2, 2, 2, 2, 0, 0, 0};
        chk_log("rotation", 5);

        // Wrap: grant 2 moves ptr to 3; then 3 wins, then ptr wraps to 0.
        clear_log();
        req_v = 4'b0100;
        tick();
        req_v = 4'b1001;
        tick();
        tick();
        chk("wrap_sel3", 64'(bus.mux_sel), 64'(3));
        req_v = 4'b0011;
        tick();
        tick();
        chk("wrap_sel0", 64'(bus.mux_sel), 64'(0));
        req_v = 4'b0010;
        tick();
        tick();
        req_v = 4'b0000;
        tick();
        e_idx = '{2, 3, 0, 1, 0, 0, 0, 0};
        e_gap = '{0, 2, 2, 2, 0, 0, 0, 0};
        chk_log("wrap", 4);

        // Backpressure on grant 1.
        clear_log();
        req_v = 4'b0010;
        rdy_v = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(bus.out_valid), 64'(1));
            chk("bp_sel",   64'(bus.mux_sel),   64'(1));
            chk("bp_data",  64'(bus.out_data),  64'(32'hB111_1111));
            chk("bp_ack",   64'(bus.ack),       64'(0));
            tick();
        end
        rdy_v = 1'b1;
        #1;
        chk("bp_release_ack", 64'(bus.ack), 64'(4'b0010));
        req_v = 4'b0000;
        tick();
        chk("bp_ack_cleared", 64'(bus.ack), 64'(0));
        chk("bp_idle_valid",  64'(bus.out_valid), 64'(0));
        e_idx = '{1, 0, 0, 0, 0, 0, 0, 0};
        chk_log("backpressure", 1);

        // Withdraw of a granted requester leaves ptr unchanged.
        clear_log();
        rdy_v = 1'b0;
        req_v = 4'b0100;
        tick();
        chk("wd_granted", 64'(bus.mux_sel), 64'(2));
        req_v = 4'b0000;
        tick();
        chk("wd_valid", 64'(bus.out_valid), 64'(0));
        chk("wd_ack",   64'(bus.ack),       64'(0));
        req_v = 4'b0101;
        tick();
        chk("wd_regrant", 64'(bus.mux_sel), 64'(2));
        rdy_v = 1'b1;
        tick();
        req_v = 4'b0001;
        tick();
        req_v = 4'b0000;
        tick();
        e_idx = '{2, 0, 0, 0, 0, 0, 0, 0};
        e_gap = '{0, 2, 0, 0, 0, 0, 0, 0};
        chk_log("withdraw", 2);

        // Asynchronous reset in the middle of a grant.
        clear_log();
        rdy_v = 1'b0;
        req_v = 4'b0010;
        tick();
        chk("ar_granted", 64'(bus.out_valid), 64'(1));
        #2;
        rdy_v = 1'b1;
        reset = 1'b1;
        #1;
        chk("ar_valid", 64'(bus.out_valid), 64'(0));
        chk("ar_busy",  64'(bus.busy),      64'(0));
        chk("ar_ack",   64'(bus.ack),       64'(0));
        chk("ar_sel",   64'(bus.mux_sel),   64'(0));
        tick();
        reset = 1'b0;
        tick();
        chk("ar_regrant", 64'(bus.mux_sel), 64'(1));
        req_v = 4'b0000;
        tick();
        e_idx = '{1, 0, 0, 0, 0, 0, 0, 0};
        chk_log("async_reset", 1);

        // Mixed directed vectors {out_ready, req}, checked by the model.
        for (int i = 0; i < 16; i++) begin
            rdy_v = vec[i][4];
            req_v = vec[i][3:0];
            tick();
        end
        req_v = 4'b0000;
        rdy_v = 1'b1;
        tick(); tick();

`ifdef ARB_LOCK_EN
        // Lock with HOLD_LIMIT=3: four single-cycle transfers to 0, then 1.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_log();
        req_v  = 4'b0011;
        lock_v = 4'b0001;
        rdy_v  = 1'b1;
        tick();
        repeat (5) tick();
        req_v  = 4'b0000;
        lock_v = 4'b0000;
        tick();
        e_idx = '{0, 0, 0, 0, 1, 0, 0, 0};
        e_gap = '{0, 1, 1, 1, 2, 0, 0, 0};
        chk_log("lock", 5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
